posit_decode_pipe: RTL

Pipelined, handshaked posit decoder, parametrised in N and ES. It unpacks one posit word per cycle into sign, special-case flags, regime value k, exponent field and a left-aligned significand. It sits between operand registers and the PPU arithmetic core. It is the registered successor of the combinational decoder, adding valid/ready flow control, stall handling and a correct left-aligned fraction with hidden bit.

---
 rtl/posit_decode_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage valid/ready posit decoder (sign, flags, regime k, exponent, left-aligned significand).
// Optional out_scale = k*2^ES + exp when POSIT_DECODE_SCALE_EN is defined.
module posit_decode_pipe #(
    parameter int N  = 16,
    parameter int ES = 1,
    parameter int S  = $clog2(N),
    parameter int EW = (ES > 0 ? ES : 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_bits,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_is_zero,
    output logic           out_is_nar,
    output logic           out_sign,
    output logic [S:0]     out_k,
    output logic [EW-1:0]  out_exp,
    output logic [N-1:0]   out_frac
`ifdef POSIT_DECODE_SCALE_EN
    ,
    output logic [S+ES:0]  out_scale
`endif
);
    logic           en1, en2, v1, sign1, zero1, nar1, reg_s1, done, special;
    logic [N-1:0]   abs_c, abs1, rem, rem_sh, frac_c;
    logic [S-1:0]   run_c, run1;
    logic [S:0]     run_w, reg_len, k_c;
    logic [EW-1:0]  exp_c;

    assign en2      = !out_valid || out_ready;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    // Regime run length: leading bits matching abs[N-2], counted below the sign position
    always_comb begin
        abs_c = in_bits[N-1] ? -in_bits : in_bits;
        run_c = '0;
        done  = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && abs_c[i] == abs_c[N-2]) run_c = run_c + S'(1);
            else done = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            sign1  <= 1'b0;
            zero1  <= 1'b0;
            nar1   <= 1'b0;
            abs1   <= '0;
            reg_s1 <= 1'b0;
            run1   <= '0;
        end else if (en1) begin
            v1     <= in_valid;
            sign1  <= in_bits[N-1];
            zero1  <= in_bits == '0;
            nar1   <= in_bits == {1'b1, {(N-1){1'b0}}};
            abs1   <= abs_c;
            reg_s1 <= abs_c[N-2];
            run1   <= run_c;
        end
    end

    // Skip sign, regime run and terminator; shifts past the LSB fill with zeros
    always_comb begin
        run_w   = (S+1)'(run1);
        reg_len = (run1 == S'(N - 1)) ? (S+1)'(N - 1) : run_w + (S+1)'(1);
        rem     = abs1 << (reg_len + (S+1)'(1));
        rem_sh  = rem << ES;
        k_c     = reg_s1 ? run_w - (S+1)'(1) : -run_w;
        exp_c   = (ES > 0) ? rem[N-1 -: EW] : '0;
        frac_c  = {1'b1, {(N-1){1'b0}}} | (rem_sh >> 1);
        special = zero1 || nar1;
    end

`ifdef POSIT_DECODE_SCALE_EN
    logic [S+ES:0] scale_c;
    assign scale_c = ((S+ES+1)'(signed'(k_c)) << ES) + (S+ES+1)'(exp_c);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_is_zero <= 1'b0;
            out_is_nar  <= 1'b0;
            out_k       <= '0;
            out_exp     <= '0;
            out_frac    <= '0;
`ifdef POSIT_DECODE_SCALE_EN
            out_scale   <= '0;
`endif
        end else if (en2) begin
            out_valid   <= v1;
            out_sign    <= sign1;
            out_is_zero <= zero1;
            out_is_nar  <= nar1;
            out_k       <= special ? '0 : k_c;
            out_exp     <= special ? '0 : exp_c;
            out_frac    <= special ? '0 : frac_c;
`ifdef POSIT_DECODE_SCALE_EN
            out_scale   <= special ? '0 : scale_c;
`endif
        end
    end
endmodule
